// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO bank configuration chain: per-channel
// config bit positions and the chain-load FSM state type.
package gpio_cfg_pkg;

    localparam int CFG_BITS       = 3;
    localparam int CFG_BIT_DIR    = 0;  // 1 = channel drives its pad
    localparam int CFG_BIT_IN_REG = 1;  // 1 = input path goes through a flop
    localparam int CFG_BIT_INV    = 2;  // 1 = input data inverted

    // Chain fill level. IDLE/LOADING/ARMED/OVERRUN map to an empty,
    // partial, exactly-full and over-full shadow image respectively.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2,
        OVERRUN = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/gpio_chan_datapath.sv
// One GPIO channel: pad drive/direction from the active config, and an
// optionally inverted, optionally registered input path back to the fabric.
module gpio_chan_datapath
    import gpio_cfg_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CFG_BITS-1:0] i_cfg,
    input  logic                i_outpad,
    input  logic                i_pad_y,
    output logic                o_pad_a,
    output logic                o_pad_dir,
    output logic                o_inpad
);

    logic w_y;
    logic r_y;

    assign w_y = i_pad_y ^ i_cfg[CFG_BIT_INV];

    // Input flop runs every cycle regardless of IN_REG, so enabling the
    // registered path never exposes a value older than one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_y;
        end
    end

    assign o_pad_a   = i_outpad;
    assign o_pad_dir = i_cfg[CFG_BIT_DIR];
    assign o_inpad   = i_cfg[CFG_BIT_IN_REG] ? r_y : w_y;

endmodule

// File: rtl/gpio_bank_cfg_chain.sv
// NUM_IO-channel GPIO bank fed by one configuration-chain segment. Bits are
// shifted into a shadow image; a commit copies it to the active image only
// when exactly CHAIN_LEN bits have been shifted since the last commit/reset,
// so a partial or over-full load never reaches the pads.
module gpio_bank_cfg_chain
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_IO = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_commit,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_err,
    input  logic [NUM_IO-1:0] iopad_outpad,
    output logic [NUM_IO-1:0] iopad_inpad,
    output logic [NUM_IO-1:0] pad_a,
    output logic [NUM_IO-1:0] pad_dir,
    input  logic [NUM_IO-1:0] pad_y
);

    localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] r_shadow;
    logic [CHAIN_LEN-1:0] r_active;
    logic [CNT_W-1:0]     r_cnt;
    cfg_state_t           r_state;
    logic                 r_valid;
    logic                 r_err;

    logic [CNT_W-1:0]     w_cnt_nxt;
    cfg_state_t           w_state_nxt;
    logic                 w_shift;
    logic                 w_accept;
    logic                 w_reject;

    // Shift and commit are mutually exclusive; a commit wins and is judged
    // on the pre-shift fill level held in r_state.
    always_comb begin
        w_shift   = ccff_en & ~cfg_commit;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_cnt_nxt = r_cnt;
        if (cfg_commit) begin
            w_accept  = (r_state == ARMED);
            w_reject  = (r_state != ARMED);
            w_cnt_nxt = CNT_ZERO;
        end else if (ccff_en && (r_cnt != CNT_SAT)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end

        if (w_cnt_nxt == CNT_ZERO) begin
            w_state_nxt = IDLE;
        end else if (w_cnt_nxt < CNT_FULL) begin
            w_state_nxt = LOADING;
        end else if (w_cnt_nxt == CNT_FULL) begin
            w_state_nxt = ARMED;
        end else begin
            w_state_nxt = OVERRUN;
        end
    end

    // Fill-level FSM and bit counter.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow shift register; untouched by commits.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_shadow <= '0;
        end else if (w_shift) begin
            r_shadow <= {r_shadow[CHAIN_LEN-2:0], ccff_head};
        end
    end

    // Active image, valid flag and single-cycle reject pulse.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_active <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
            end
        end
    end

    assign ccff_tail = r_shadow[CHAIN_LEN-1];
    assign cfg_valid = r_valid;
    assign cfg_err   = r_err;

    for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_chan
        gpio_chan_datapath u_chan (
            .i_clk     (prog_clk),
            .i_rst_n   (pReset),
            .i_cfg     (r_active[gi*CFG_BITS +: CFG_BITS]),
            .i_outpad  (iopad_outpad[gi]),
            .i_pad_y   (pad_y[gi]),
            .o_pad_a   (pad_a[gi]),
            .o_pad_dir (pad_dir[gi]),
            .o_inpad   (iopad_inpad[gi])
        );
    end

endmodule

// File: tb/tb_gpio_bank_cfg_chain.sv
// Bench for gpio_bank_cfg_chain: directed scenarios with literal expectations
// plus randomized load/commit traffic, all outputs compared every cycle
// against a behavioural model of the chain, commit rule and channel paths.
module tb_gpio_bank_cfg_chain;

    localparam int NUM_IO = 4;
    localparam int CB     = 3;
    localparam int CL     = NUM_IO * CB;

    logic              prog_clk = 1'b0;
    logic              pReset = 1'b0;
    logic              ccff_head = 1'b0;
    logic              ccff_en = 1'b0;
    logic              cfg_commit = 1'b0;
    logic              ccff_tail;
    logic              cfg_valid;
    logic              cfg_err;
    logic [NUM_IO-1:0] iopad_outpad = '0;
    logic [NUM_IO-1:0] iopad_inpad;
    logic [NUM_IO-1:0] pad_a;
    logic [NUM_IO-1:0] pad_dir;
    logic [NUM_IO-1:0] pad_y = '0;

    int n_checks = 0;
    int n_errors = 0;

    gpio_bank_cfg_chain #(.NUM_IO(NUM_IO)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .cfg_commit   (cfg_commit),
        .ccff_tail    (ccff_tail),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err),
        .iopad_outpad (iopad_outpad),
        .iopad_inpad  (iopad_inpad),
        .pad_a        (pad_a),
        .pad_dir      (pad_dir),
        .pad_y        (pad_y)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] is the bit shifted in k shifts ago (newest first); anything
    // older than CL shifts has fallen off the end of the chain.
    bit       hist[$];
    int       m_cnt = 0;
    bit [2:0] m_act [NUM_IO];
    bit       m_yreg[NUM_IO];
    bit       m_valid = 0;
    bit       m_err = 0;
    bit       m_live = 0;

    function automatic bit m_sh(int k);
        return (k < hist.size()) ? hist[k] : 1'b0;
    endfunction

    always @(posedge prog_clk) begin
        if (!pReset) begin
            hist.delete();
            m_cnt   = 0;
            m_valid = 0;
            m_err   = 0;
            for (int i = 0; i < NUM_IO; i++) begin
                m_act[i]  = 3'b000;
                m_yreg[i] = 1'b0;
            end
            m_live = 1;
        end else begin
            for (int i = 0; i < NUM_IO; i++) m_yreg[i] = pad_y[i] ^ m_act[i][2];
            m_err = 0;
            if (cfg_commit) begin
                if (m_cnt == CL) begin
                    for (int i = 0; i < NUM_IO; i++)
                        for (int b = 0; b < CB; b++) m_act[i][b] = m_sh(i*CB + b);
                    m_valid = 1;
                end else begin
                    m_err = 1;
                end
                m_cnt = 0;
            end else if (ccff_en) begin
                hist.push_front(ccff_head);
                if (hist.size() > CL) void'(hist.pop_back());
                if (m_cnt < CL + 1) m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge prog_clk) begin
        logic [NUM_IO-1:0] e_dir, e_in;
        if (m_live) begin
            for (int i = 0; i < NUM_IO; i++) begin
                e_dir[i] = m_act[i][0];
                e_in[i]  = m_act[i][1] ? m_yreg[i] : (pad_y[i] ^ m_act[i][2]);
            end
            chk("m_pad_dir",   32'(pad_dir),     32'(e_dir));
            chk("m_pad_a",     32'(pad_a),       32'(iopad_outpad));
            chk("m_inpad",     32'(iopad_inpad), 32'(e_in));
            chk("m_cfg_valid", 32'(cfg_valid),   32'(m_valid));
            chk("m_cfg_err",   32'(cfg_err),     32'(m_err));
            chk("m_ccff_tail", 32'(ccff_tail),   32'(m_sh(CL-1)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Shifts v[n-1] first, so with n == CL bit v[k] lands in shadow[k].
    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            ccff_head = v[k];
            ccff_en   = 1'b1;
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        logic [15:0] rv;
        // Reset then idle
        pReset = 1'b0;
        tick(); tick();
        pReset = 1'b1;
        repeat (5) tick();
        chk("rst_pad_dir", 32'(pad_dir), 32'h0);
        chk("rst_valid",   32'(cfg_valid), 32'h0);
        chk("rst_err",     32'(cfg_err), 32'h0);
        chk("rst_tail",    32'(ccff_tail), 32'h0);
        chk("rst_inpad",   32'(iopad_inpad), 32'h0);

        // Channel 0 drives, others quiet
        shift_bits(16'h001, CL);
        commit();
        chk("c0_pad_dir", 32'(pad_dir), 32'h1);
        chk("c0_valid",   32'(cfg_valid), 32'h1);
        iopad_outpad = 4'b1010;
        #1;
        chk("c0_pad_a", 32'(pad_a), 32'hA);

        // Short load rejected
        rv = 16'($urandom);
        shift_bits(rv, 7);
        commit();
        chk("short_err",     32'(cfg_err), 32'h1);
        chk("short_pad_dir", 32'(pad_dir), 32'h1);
        tick();
        chk("short_err_clr", 32'(cfg_err), 32'h0);

        // Over-long load rejected
        rv = 16'($urandom);
        shift_bits(rv, 13);
        commit();
        chk("over_err",     32'(cfg_err), 32'h1);
        chk("over_pad_dir", 32'(pad_dir), 32'h1);
        chk("over_valid",   32'(cfg_valid), 32'h1);
        tick();
        chk("over_err_clr", 32'(cfg_err), 32'h0);

        // Channel 2 registered + inverted, channel 3 plain
        shift_bits(16'h181, CL);
        commit();
        pad_y = 4'b0000;
        tick();
        chk("c2_inv_lo", 32'(iopad_inpad[2]), 32'h1);
        chk("c3_lo",     32'(iopad_inpad[3]), 32'h0);
        pad_y = 4'b0100;
        #1;
        chk("c2_reg_hold", 32'(iopad_inpad[2]), 32'h1);
        tick();
        chk("c2_reg_upd", 32'(iopad_inpad[2]), 32'h0);
        pad_y = 4'b1100;
        #1;
        chk("c3_comb", 32'(iopad_inpad[3]), 32'h1);

        // Shift and commit together when exactly full
        shift_bits(16'hA5C, CL);
        ccff_head  = 1'b0;
        ccff_en    = 1'b1;
        cfg_commit = 1'b1;
        tick();
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
        chk("sim_pad_dir", 32'(pad_dir), 32'hE);
        chk("sim_err",     32'(cfg_err), 32'h0);
        chk("sim_tail",    32'(ccff_tail), 32'h1);
        shift_bits(16'h3C7, CL);
        chk("sim_tail12",  32'(ccff_tail), 32'h0);

        // Reset mid-shift
        rv = 16'($urandom);
        shift_bits(rv, 6);
        pReset = 1'b0;
        tick();
        pReset = 1'b1;
        chk("mid_pad_dir", 32'(pad_dir), 32'h0);
        chk("mid_valid",   32'(cfg_valid), 32'h0);
        chk("mid_tail",    32'(ccff_tail), 32'h0);
        shift_bits(16'h249, CL);
        commit();
        chk("mid_reload_dir",   32'(pad_dir), 32'hF);
        chk("mid_reload_valid", 32'(cfg_valid), 32'h1);

        // Randomized loads of varying length with random pad traffic
        for (int it = 0; it < 150; it++) begin
            int n;
            n = $urandom_range(10, 14);
            for (int k = 0; k < n; ) begin
                pad_y        = 4'($urandom);
                iopad_outpad = 4'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    ccff_en   = 1'b1;
                    ccff_head = 1'($urandom_range(0, 1));
                    k++;
                end else begin
                    ccff_en = 1'b0;
                end
                tick();
            end
            ccff_en    = 1'($urandom_range(0, 1));
            ccff_head  = 1'($urandom_range(0, 1));
            cfg_commit = 1'b1;
            pad_y      = 4'($urandom);
            tick();
            cfg_commit = 1'b0;
            ccff_en    = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                pReset = 1'b0;
                tick();
                pReset = 1'b1;
            end
            tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
